// File: rtl/paddle_ctrl_if.sv
// Bundles the keyboard/ball inputs and paddle geometry outputs of the Breakout paddle.
// The master side drives keys and game events; the slave side is the paddle controller.
interface paddle_ctrl_if;
  logic [7:0] keycode;
  logic       ball_out;
  logic       shrink;
  logic [9:0] bar_x;
  logic [9:0] bar_y;
  logic [9:0] bar_half_w;
  logic [9:0] bar_half_h;
  logic       holding;
  logic       launch;

  modport master (
    output keycode, ball_out, shrink,
    input  bar_x, bar_y, bar_half_w, bar_half_h, holding, launch
  );

  modport slave (
    input  keycode, ball_out, shrink,
    output bar_x, bar_y, bar_half_w, bar_half_h, holding, launch
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Breakout paddle controller: accelerating keyboard motion, saturating edge clamp,
// wide/narrow size mode and the serve/play/recenter sequence that releases the ball.
module paddle_ctrl #(
  parameter int         X_BEGIN      = 320,
  parameter int         Y_POS        = 460,
  parameter int         X_MIN        = 10,
  parameter int         X_MAX        = 639,
  parameter int         HALF_W       = 20,
  parameter int         HALF_H       = 3,
  parameter int         STEP_MIN     = 1,
  parameter int         STEP_MAX     = 6,
  parameter int         ACCEL_FRAMES = 4,
  parameter logic [7:0] KEY_LEFT     = 8'h04,
  parameter logic [7:0] KEY_RIGHT    = 8'h07,
  parameter logic [7:0] KEY_LAUNCH   = 8'h2C
) (
  input logic          frame_clk,
  input logic          Reset,
  paddle_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SERVE    = 2'd0,
    ST_PLAY     = 2'd1,
    ST_RECENTER = 2'd2
  } state_e;

  typedef logic signed [10:0] coord_t;

  localparam logic [9:0] X_BEGIN_U   = 10'(X_BEGIN);
  localparam logic [9:0] Y_POS_U     = 10'(Y_POS);
  localparam logic [9:0] X_MIN_U     = 10'(X_MIN);
  localparam logic [9:0] X_MAX_U     = 10'(X_MAX);
  localparam logic [9:0] HALF_WIDE   = 10'(HALF_W);
  localparam logic [9:0] HALF_NARROW = 10'(HALF_W / 2);
  localparam logic [9:0] HALF_H_U    = 10'(HALF_H);
  localparam logic [9:0] SLEW_U      = 10'(STEP_MAX);
  localparam logic [7:0] STEP_MIN_U  = 8'(STEP_MIN);
  localparam logic [7:0] STEP_MAX_U  = 8'(STEP_MAX);
  localparam logic [7:0] ACC_LAST    = 8'(ACCEL_FRAMES - 1);
  localparam coord_t     X_BEGIN_S   = coord_t'(X_BEGIN);
  localparam coord_t     SLEW_S      = coord_t'(STEP_MAX);

  // Signed 11-bit saturation keeps moves past either edge from wrapping.
  function automatic logic [9:0] clamp_x(input coord_t v, input logic [9:0] lo,
                                         input logic [9:0] hi);
    logic [9:0] r;
    if (v < $signed({1'b0, lo})) begin
      r = lo;
    end else if (v > $signed({1'b0, hi})) begin
      r = hi;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [9:0]        bar_x_q, bar_x_d;
  logic [7:0]        step_q, step_d;
  logic [7:0]        count_q, count_d;
  logic signed [1:0] last_dir_q, last_dir_d;
  logic              launch_q, launch_d;
  logic              holding_q;
  logic [9:0]        half_w_q;
  logic [9:0]        bar_y_q;
  logic [9:0]        bar_half_h_q;

  logic signed [1:0] dir_s;
  logic [9:0]        half_s, lo_s, hi_s;
  coord_t            pos_s, step_s, moved_s, offset_s;
  logic [9:0]        moved_x_s, hold_x_s, slew_x_s;
  logic              near_s;
  logic [7:0]        acc_step_s, acc_count_s;

  // Key decode, legal range for the current size and candidate positions.
  always_comb begin
    if (bus.keycode == KEY_LEFT) begin
      dir_s = -2'sd1;
    end else if (bus.keycode == KEY_RIGHT) begin
      dir_s = 2'sd1;
    end else begin
      dir_s = 2'sd0;
    end
    half_s  = bus.shrink ? HALF_NARROW : HALF_WIDE;
    lo_s    = X_MIN_U + half_s;
    hi_s    = X_MAX_U - half_s;
    pos_s   = $signed({1'b0, bar_x_q});
    step_s  = $signed({3'b000, step_q});
    if (dir_s > 2'sd0) begin
      moved_s = pos_s + step_s;
    end else if (dir_s < 2'sd0) begin
      moved_s = pos_s - step_s;
    end else begin
      moved_s = pos_s;
    end
    moved_x_s = clamp_x(moved_s, lo_s, hi_s);
    hold_x_s  = clamp_x(pos_s, lo_s, hi_s);
    offset_s  = pos_s - X_BEGIN_S;
    near_s    = (offset_s <= SLEW_S) && (offset_s >= -SLEW_S);
    if (near_s) begin
      slew_x_s = X_BEGIN_U;
    end else if (offset_s > 11'sd0) begin
      slew_x_s = bar_x_q - SLEW_U;
    end else begin
      slew_x_s = bar_x_q + SLEW_U;
    end
  end

  // Acceleration: count wraps every ACCEL_FRAMES held frames, bumping the step on the last one.
  always_comb begin
    if ((dir_s == 2'sd0) || (dir_s != last_dir_q)) begin
      acc_step_s  = STEP_MIN_U;
      acc_count_s = 8'd0;
    end else begin
      acc_count_s = (count_q == ACC_LAST) ? 8'd0 : count_q + 8'd1;
      if ((acc_count_s == ACC_LAST) && (step_q < STEP_MAX_U)) begin
        acc_step_s = step_q + 8'd1;
      end else begin
        acc_step_s = step_q;
      end
    end
  end

  // Next-state selection for the serve/play/recenter sequence.
  always_comb begin
    state_d    = state_q;
    bar_x_d    = bar_x_q;
    step_d     = step_q;
    count_d    = count_q;
    last_dir_d = last_dir_q;
    launch_d   = 1'b0;
    case (state_q)
      ST_SERVE: begin
        bar_x_d    = moved_x_s;
        step_d     = acc_step_s;
        count_d    = acc_count_s;
        last_dir_d = dir_s;
        if (bus.keycode == KEY_LAUNCH) begin
          launch_d = 1'b1;
          state_d  = ST_PLAY;
        end else begin
          state_d  = ST_SERVE;
        end
      end
      ST_PLAY: begin
        if (bus.ball_out) begin
          bar_x_d    = hold_x_s;
          step_d     = STEP_MIN_U;
          count_d    = 8'd0;
          last_dir_d = 2'sd0;
          state_d    = ST_RECENTER;
        end else begin
          bar_x_d    = moved_x_s;
          step_d     = acc_step_s;
          count_d    = acc_count_s;
          last_dir_d = dir_s;
          state_d    = ST_PLAY;
        end
      end
      ST_RECENTER: begin
        bar_x_d    = slew_x_s;
        step_d     = STEP_MIN_U;
        count_d    = 8'd0;
        last_dir_d = 2'sd0;
        state_d    = near_s ? ST_SERVE : ST_RECENTER;
      end
      default: begin
        bar_x_d    = X_BEGIN_U;
        step_d     = STEP_MIN_U;
        count_d    = 8'd0;
        last_dir_d = 2'sd0;
        state_d    = ST_SERVE;
      end
    endcase
  end

  // State and registered outputs; holding mirrors the state being entered.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_SERVE;
      bar_x_q      <= X_BEGIN_U;
      step_q       <= STEP_MIN_U;
      count_q      <= 8'd0;
      last_dir_q   <= 2'sd0;
      launch_q     <= 1'b0;
      holding_q    <= 1'b1;
      half_w_q     <= HALF_WIDE;
      bar_y_q      <= Y_POS_U;
      bar_half_h_q <= HALF_H_U;
    end else begin
      state_q      <= state_d;
      bar_x_q      <= bar_x_d;
      step_q       <= step_d;
      count_q      <= count_d;
      last_dir_q   <= last_dir_d;
      launch_q     <= launch_d;
      holding_q    <= (state_d == ST_SERVE);
      half_w_q     <= half_s;
      bar_y_q      <= Y_POS_U;
      bar_half_h_q <= HALF_H_U;
    end
  end

  assign bus.bar_x      = bar_x_q;
  assign bus.bar_y      = bar_y_q;
  assign bus.bar_half_w = half_w_q;
  assign bus.bar_half_h = bar_half_h_q;
  assign bus.holding    = holding_q;
  assign bus.launch     = launch_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus randomized key bursts, all checked
// against a frame-level reference model of paddle position, speed and game mode.
module tb_paddle_ctrl;

  localparam logic [7:0] KL = 8'h04;
  localparam logic [7:0] KR = 8'h07;
  localparam logic [7:0] KS = 8'h2C;
  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_RCTR  = 2;

  logic frame_clk = 1'b0;
  logic Reset;
  paddle_ctrl_if pif();

  paddle_ctrl dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(pif.slave)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position, run length of the held direction, game mode.
  int m_x, m_run, m_last, m_mode, m_half, m_launch;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_run = 0; m_last = 0; m_mode = M_SERVE; m_half = 20; m_launch = 0;
  endtask

  task automatic model_frame(input logic [7:0] k, input bit bo, input bit sh);
    int dir, half, lo, hi, step, off;
    dir  = (k == KL) ? -1 : ((k == KR) ? 1 : 0);
    half = sh ? 10 : 20;
    lo   = 10 + half;
    hi   = 639 - half;
    step = 1 + m_run / 4;
    if (step > 6) step = 6;
    m_launch = 0;
    if (m_mode == M_RCTR) begin
      m_run = 0; m_last = 0;
      off = m_x - 320;
      if (off <= 6 && off >= -6) begin
        m_x = 320; m_mode = M_SERVE;
      end else begin
        m_x = m_x + ((off > 0) ? -6 : 6);
      end
    end else if (m_mode == M_PLAY && bo) begin
      m_x = (m_x < lo) ? lo : ((m_x > hi) ? hi : m_x);
      m_run = 0; m_last = 0; m_mode = M_RCTR;
    end else begin
      m_x = m_x + dir * step;
      m_x = (m_x < lo) ? lo : ((m_x > hi) ? hi : m_x);
      if (dir == 0) begin
        m_run = 0; m_last = 0;
      end else if (dir == m_last) begin
        m_run++;
      end else begin
        m_last = dir; m_run = 1;
      end
      if (m_mode == M_SERVE && k == KS) begin
        m_launch = 1; m_mode = M_PLAY;
      end
    end
    m_half = half;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".bar_x"}, int'(pif.bar_x), m_x);
    chk({ctx, ".half_w"}, int'(pif.bar_half_w), m_half);
    chk({ctx, ".holding"}, int'(pif.holding), (m_mode == M_SERVE) ? 1 : 0);
    chk({ctx, ".launch"}, int'(pif.launch), m_launch);
    chk({ctx, ".bar_y"}, int'(pif.bar_y), 460);
    chk({ctx, ".half_h"}, int'(pif.bar_half_h), 3);
  endtask

  // Called at a negative edge: apply inputs, advance the model, sample at the next negedge.
  task automatic frame(input logic [7:0] k, input bit bo, input bit sh, input string ctx);
    pif.keycode  = k;
    pif.ball_out = bo;
    pif.shrink   = sh;
    model_frame(k, bo, sh);
    @(posedge frame_clk);
    @(negedge frame_clk);
    check_outputs(ctx);
  endtask

  int plan1[12] = '{321, 322, 323, 324, 326, 328, 330, 332, 335, 338, 341, 344};
  int x0, len, sel, guard;
  bit sh;
  logic [7:0] k;

  initial begin
    Reset = 1'b1;
    pif.keycode = 8'h00; pif.ball_out = 1'b0; pif.shrink = 1'b0;
    model_reset();
    repeat (2) @(negedge frame_clk);
    check_outputs("reset");
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      frame(KR, 1'b0, 1'b0, "accel");
      chk("accel.plan", int'(pif.bar_x), plan1[i]);
    end
    chk("accel.holding", int'(pif.holding), 1);

    for (int i = 0; i < 80; i++) frame(KL, 1'b0, 1'b0, "left_edge");
    chk("left_edge.sat", int'(pif.bar_x), 30);

    for (int i = 0; i < 3; i++) begin
      frame(KS, 1'b0, 1'b0, "launch");
      chk("launch.pulse", int'(pif.launch), (i == 0) ? 1 : 0);
      chk("launch.holding", int'(pif.holding), 0);
    end

    guard = 0;
    while (m_x < 480 && guard < 200) begin
      frame(KR, 1'b0, 1'b0, "play_move");
      guard++;
    end
    chk("play_move.reached", (m_x >= 480) ? 1 : 0, 1);
    x0 = m_x;
    frame(KR, 1'b1, 1'b0, "ball_out");
    chk("ball_out.discard", int'(pif.bar_x), x0);
    chk("ball_out.holding", int'(pif.holding), 0);
    guard = 0;
    while (m_mode != M_SERVE && guard < 200) begin
      frame(KL, 1'b1, 1'b0, "recenter");
      guard++;
    end
    chk("recenter.done", (m_mode == M_SERVE) ? 1 : 0, 1);
    chk("recenter.home", int'(pif.bar_x), 320);
    chk("recenter.holding", int'(pif.holding), 1);

    guard = 0;
    while (m_x != 629 && guard < 200) begin
      frame(KR, 1'b0, 1'b1, "narrow_edge");
      guard++;
    end
    chk("narrow_edge.sat", int'(pif.bar_x), 629);
    chk("narrow_edge.half", int'(pif.bar_half_w), 10);
    frame(KR, 1'b0, 1'b0, "widen");
    chk("widen.reclamp", int'(pif.bar_x), 619);
    chk("widen.half", int'(pif.bar_half_w), 20);

    frame(KS, 1'b0, 1'b0, "serve2");
    frame(8'h00, 1'b1, 1'b0, "lose2");
    for (int i = 0; i < 3; i++) frame(8'h00, 1'b0, 1'b0, "recenter2");
    chk("recenter2.moving", int'(pif.bar_x), 619 - 18);
    Reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    chk("async_reset.x", int'(pif.bar_x), 320);
    @(negedge frame_clk);
    Reset = 1'b0;

    for (int b = 0; b < 70; b++) begin
      len = $urandom_range(1, 12);
      sel = $urandom_range(0, 11);
      if (sel < 4) k = KR;
      else if (sel < 8) k = KL;
      else if (sel < 10) k = KS;
      else if (sel == 10) k = 8'h15;
      else k = 8'h00;
      sh = ($urandom_range(0, 3) == 0);
      for (int f = 0; f < len; f++) begin
        frame(k, ($urandom_range(0, 15) == 0), sh, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Player paddle controller for Breakout, the parametrised successor to the fixed-size bar: keyboard-driven horizontal motion with acceleration, saturating edge clamp, a wide/narrow size mode, and a serve/play/recenter state machine. It sits between the USB keycode path and the ball/collision and colour-mapper logic. It produces paddle geometry and a one-frame launch pulse that releases the ball.

Parameters:
X_BEGIN, 320, paddle centre X after reset and after each recenter
Y_POS, 460, fixed paddle centre Y
X_MIN, 10, leftmost allowed paddle left edge
X_MAX, 639, rightmost allowed paddle right edge
HALF_W, 20, paddle half-width in normal mode; must be even
HALF_H, 3, paddle half-height
STEP_MIN, 1, initial per-frame step when a direction key is first held
STEP_MAX, 6, step ceiling; also the recenter slew rate
ACCEL_FRAMES, 4, consecutive same-direction frames per +1 step
KEY_LEFT, 8'h04, keycode for move left (A)
KEY_RIGHT, 8'h07, keycode for move right (D)
KEY_LAUNCH, 8'h2C, keycode for launch (space)

Ports:
frame_clk  input  1  frame-rate clock (vsync)
Reset  input  1  reset, asynchronous, active-high
keycode  input  8  current key; 8'h00 = none
ball_out  input  1  ball lost below paddle (level, sampled per frame)
shrink  input  1  1 = narrow mode, half-width HALF_W/2
bar_x  output  10  paddle centre X
bar_y  output  10  paddle centre Y (constant Y_POS)
bar_half_w  output  10  current half-width
bar_half_h  output  10  constant HALF_H
holding  output  1  1 while in SERVE (ball rides on paddle)
launch  output  1  one-frame pulse releasing the ball

Behaviour:
- Reset: asynchronous, active-high. It sets state=SERVE, bar_x=X_BEGIN, step=STEP_MIN, accel count=0, last direction=none, launch=0, holding=1. All outputs are registered and update on posedge frame_clk.
- Internal arithmetic is 11-bit signed. No 10-bit wrap-around is permitted at either edge.
- half = shrink ? HALF_W/2 : HALF_W. bar_half_w follows shrink with one-frame latency.
- Legal centre range is [X_MIN+half, X_MAX-half].
- Move logic (SERVE and PLAY only):
  - dir = -1 for KEY_LEFT, +1 for KEY_RIGHT, 0 otherwise.
  - If dir=0 or dir differs from last dir: step=STEP_MIN, count=0.
  - Otherwise count increments. When count reaches ACCEL_FRAMES-1, count resets to 0 and step = min(step+1, STEP_MAX).
  - bar_x_next = bar_x + dir*step (the pre-update step), saturated to the legal range. A move into an edge lands exactly on the edge; it is not refused.
- Size change: in the frame shrink deasserts, bar_x is re-clamped to the wide legal range, whatever the keycode.
- States:
  - SERVE: moves per above. On keycode==KEY_LAUNCH, launch=1 for exactly that frame and the next state is PLAY. A held launch key produces no further pulse until SERVE is re-entered.
  - PLAY: moves per above. If ball_out=1, the next state is RECENTER; the movement for that frame is discarded, and step and count are reset.
  - RECENTER: keys are ignored. Each frame bar_x moves toward X_BEGIN by STEP_MAX. If |bar_x-X_BEGIN| <= STEP_MAX, then bar_x=X_BEGIN and the next state is SERVE.
- ball_out is ignored in SERVE and RECENTER.
- holding = (state==SERVE). launch is 0 in every other frame.
- Reset asserted mid-RECENTER or mid-acceleration returns immediately to reset values.

Test Plan:
1. Reset, hold KEY_RIGHT for 12 frames → bar_x 320→321,322,323,324,326,328,330,332,335,338,341,344; holding=1.
2. Hold KEY_LEFT from bar_x=35, shrink=0 → bar_x saturates at 30 and stays at 30; no underflow.
3. In SERVE press KEY_LAUNCH for 3 frames → launch=1 for 1 frame only, holding 1→0, state PLAY.
4. In PLAY with bar_x=500, pulse ball_out → next frame holding=0 and bar_x=500 (movement discarded); bar_x then steps 494,488,…,326, then 320; SERVE and holding=1 one frame later.
5. shrink=1, drive bar_x to 629 (limit 639-10), then deassert shrink → bar_x=619 next frame, bar_half_w=20.
6. Assert Reset during RECENTER at bar_x=400 → bar_x=320, launch=0, holding=1 asynchronously.
